// File: rtl/line_mem_responder.sv
// Memory-side responder for L1 line transfers: streams a line out (fill)
// or absorbs one (writeback) from a word-addressed store after a fixed latency.
module line_mem_responder #(
  parameter int WORDS   = 4,
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 3
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        next,
  output logic        done,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    XFER,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic            we_q, we_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic [3:0]      lat_q, lat_d;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   widx;
  logic            accept;
  logic            last;
  logic            mem_we;
  logic            unused_addr;

  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // base is line-aligned, so the add never carries out of the line
  assign widx   = base_q + AW'(cnt_q);
  assign accept = (state_q == XFER) && (!we_q || wvalid);
  assign last   = (cnt_q == WW'(WORDS - 1));
  assign mem_we = (state_q == XFER) && we_q && wvalid;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // store is deliberately not reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = req_addr[AW+1:2] & ~AW'(WORDS - 1);
          we_d   = req_we;
          cnt_d  = '0;
          if (LATENCY == 0) begin
            state_d = XFER;
          end else begin
            state_d = LAT;
            lat_d   = 4'(LATENCY);
          end
        end
      end
      LAT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    rvalid    = 1'b0;
    next      = 1'b0;
    done      = 1'b0;
    rdata     = '0;
    if (!CLR) begin
      unique case (state_q)
        IDLE: req_ready = 1'b1;
        LAT:  busy = 1'b1;
        XFER: begin
          busy   = 1'b1;
          rvalid = !we_q;
          next   = !we_q || wvalid;
          rdata  = we_q ? 32'd0 : mem[widx];
        end
        DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
      endcase
    end
  end

endmodule
